// File: rtl/rst_sequencer.sv
// Reset sequencer behind the clock manager. It synchronises the lock indication, then releases
// the peripheral reset and the core reset in order, and counts lock-loss events.
`timescale 1ns/1ps

module rst_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES = 16,
    parameter int unsigned CORE_DELAY_CYCLES  = 8,
    parameter int unsigned SW_RST_CYCLES      = 4
) (
    input  logic       CLK_IN,
    input  logic       RST_N_IN,
    input  logic       LOCKED_IN,
    input  logic       SW_RST_REQ_IN,
    output logic       RST_PERIPH_OUT,
    output logic       RST_CORE_OUT,
    output logic       READY_OUT,
    output logic [2:0] STATE_OUT,
    output logic [3:0] LOSS_CNT_OUT
);

    localparam int unsigned MAX_AB  = (LOCK_STABLE_CYCLES > CORE_DELAY_CYCLES) ?
                                      LOCK_STABLE_CYCLES : CORE_DELAY_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > SW_RST_CYCLES) ? MAX_AB : SW_RST_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned LOSS_W  = 4;

    typedef enum logic [2:0] {
        S_HOLD   = 3'd0,
        S_STABLE = 3'd1,
        S_PERIPH = 3'd2,
        S_RUN    = 3'd3,
        S_SWRST  = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [LOSS_W-1:0]   loss_cnt, loss_nxt;
    logic                meta, lock_sync;
    logic                periph_nxt, core_nxt, ready_nxt;

    // State register, lock synchroniser and registered outputs
    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            meta           <= 1'b0;
            lock_sync      <= 1'b0;
            state          <= S_HOLD;
            cnt            <= '0;
            loss_cnt       <= '0;
            RST_PERIPH_OUT <= 1'b1;
            RST_CORE_OUT   <= 1'b1;
            READY_OUT      <= 1'b0;
        end else begin
            meta           <= LOCKED_IN;
            lock_sync      <= meta;
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            loss_cnt       <= loss_nxt;
            RST_PERIPH_OUT <= periph_nxt;
            RST_CORE_OUT   <= core_nxt;
            READY_OUT      <= ready_nxt;
        end
    end

    // Next state, counter and output decode; lock loss overrides every other transition
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        loss_nxt   = loss_cnt;
        periph_nxt = 1'b1;
        core_nxt   = 1'b1;
        ready_nxt  = 1'b0;

        if ((state != S_HOLD) && !lock_sync) begin
            state_nxt = S_HOLD;
            if (loss_cnt != {LOSS_W{1'b1}}) begin
                loss_nxt = loss_cnt + LOSS_W'(1);
            end
        end else begin
            case (state)
                S_HOLD: begin
                    if (lock_sync) state_nxt = S_STABLE;
                end
                S_STABLE: begin
                    if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) state_nxt = S_PERIPH;
                    else                                        cnt_nxt   = cnt + CNT_W'(1);
                end
                S_PERIPH: begin
                    if (cnt == CNT_W'(CORE_DELAY_CYCLES - 1)) state_nxt = S_RUN;
                    else                                       cnt_nxt   = cnt + CNT_W'(1);
                end
                S_RUN: begin
                    if (SW_RST_REQ_IN) state_nxt = S_SWRST;
                end
                S_SWRST: begin
                    if (cnt == CNT_W'(SW_RST_CYCLES - 1)) state_nxt = S_PERIPH;
                    else                                   cnt_nxt   = cnt + CNT_W'(1);
                end
                default: state_nxt = S_HOLD;
            endcase
        end

        // Every state entry restarts the shared counter
        if (state_nxt != state) cnt_nxt = '0;

        case (state_nxt)
            S_PERIPH: periph_nxt = 1'b0;
            S_RUN: begin
                periph_nxt = 1'b0;
                core_nxt   = 1'b0;
                ready_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    assign STATE_OUT    = state;
    assign LOSS_CNT_OUT = loss_cnt;

endmodule
